// File: rtl/train_step_sdiv_4s_3s_seq.sv
// Sequential signed divider (radix-2 restoring on magnitudes, C truncation), valid/ready handshakes.
// Optional divide-by-zero flag output enabled by defining TRAIN_STEP_SDIV_DBZ_FLAG_EN.
module train_step_sdiv_4s_3s_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 4,
    parameter int din1_WIDTH = 3
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [din0_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem
`ifdef TRAIN_STEP_SDIV_DBZ_FLAG_EN
    ,
    output logic                  dbz
`endif
);

    localparam int CW = (din0_WIDTH > 1) ? $clog2(din0_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(din0_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t r_state, w_nextState;

    logic [din0_WIDTH:0]   r_dividend;
    logic [din1_WIDTH:0]   r_divisor;
    logic [din1_WIDTH:0]   r_partial;
    logic [din0_WIDTH-1:0] r_quotMag;
    logic [CW-1:0]         r_count;
    logic                  r_sign0;
    logic                  r_sign1;
    logic                  r_zero;
    logic [din0_WIDTH-1:0] r_quot;
    logic [din1_WIDTH-1:0] r_rem;

    logic                  w_accept;
    logic                  w_quotBit;
    logic [din0_WIDTH:0]   w_din0Ext;
    logic [din0_WIDTH:0]   w_absDin0;
    logic [din1_WIDTH:0]   w_din1Ext;
    logic [din1_WIDTH:0]   w_absDin1;
    logic [din1_WIDTH:0]   w_shifted;
    logic [din1_WIDTH:0]   w_diff;
    logic [din1_WIDTH-1:0] w_remMag;
    logic [din0_WIDTH-1:0] w_quotFinal;
    logic [din1_WIDTH-1:0] w_remFinal;

    // Magnitudes are one bit wider than the operands so that |MIN| is representable.
    assign w_din0Ext = {din0[din0_WIDTH-1], din0};
    assign w_din1Ext = {din1[din1_WIDTH-1], din1};
    assign w_absDin0 = din0[din0_WIDTH-1] ? -w_din0Ext : w_din0Ext;
    assign w_absDin1 = din1[din1_WIDTH-1] ? -w_din1Ext : w_din1Ext;

    assign w_accept  = in_valid & in_ready;
    assign w_shifted = (r_partial << 1) | {{din1_WIDTH{1'b0}}, r_dividend[din0_WIDTH-1]};
    assign w_quotBit = (w_shifted >= r_divisor);
    assign w_diff    = w_shifted - r_divisor;
    assign w_remMag  = r_partial[din1_WIDTH-1:0];

    assign w_quotFinal = r_zero ? '1 : ((r_sign0 ^ r_sign1) ? -r_quotMag : r_quotMag);
    assign w_remFinal  = r_zero ? '0 : (r_sign0 ? -w_remMag : w_remMag);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_nextState = CALC;
                end
            end
            CALC: begin
                if (r_count == LAST) begin
                    w_nextState = FIXUP;
                end
            end
            FIXUP: begin
                w_nextState = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // A zero divisor still runs the full CALC sequence so latency is data independent.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_partial  <= '0;
            r_quotMag  <= '0;
            r_count    <= '0;
            r_sign0    <= 1'b0;
            r_sign1    <= 1'b0;
            r_zero     <= 1'b0;
            r_quot     <= '0;
            r_rem      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dividend <= w_absDin0;
                        r_divisor  <= w_absDin1;
                        r_partial  <= '0;
                        r_quotMag  <= '0;
                        r_count    <= '0;
                        r_sign0    <= din0[din0_WIDTH-1];
                        r_sign1    <= din1[din1_WIDTH-1];
                        r_zero     <= (din1 == '0);
                    end
                end
                CALC: begin
                    r_dividend <= r_dividend << 1;
                    r_partial  <= w_quotBit ? w_diff : w_shifted;
                    r_quotMag  <= {r_quotMag[din0_WIDTH-2:0], w_quotBit};
                    r_count    <= r_count + CW'(1);
                end
                FIXUP: begin
                    r_quot <= w_quotFinal;
                    r_rem  <= w_remFinal;
                end
                default: begin
                end
            endcase
        end
    end

    assign quot = r_quot;
    assign rem  = r_rem;

`ifdef TRAIN_STEP_SDIV_DBZ_FLAG_EN
    logic r_dbz;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_dbz <= 1'b0;
        end else if (r_state == FIXUP) begin
            r_dbz <= r_zero;
        end else if (out_valid && out_ready) begin
            r_dbz <= 1'b0;
        end
    end

    assign dbz = r_dbz;
`endif

endmodule

// File: tb/tb_train_step_sdiv_4s_3s_seq.sv
// Self-checking bench for train_step_sdiv_4s_3s_seq: scoreboard of C-truncation reference results.
// Exercises the dbz flag when TRAIN_STEP_SDIV_DBZ_FLAG_EN is defined.
module tb_train_step_sdiv_4s_3s_seq;

    logic       ap_clk = 1'b0;
    logic       ap_rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] din0;
    logic [2:0] din1;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] quot;
    logic [2:0] rem;
`ifdef TRAIN_STEP_SDIV_DBZ_FLAG_EN
    logic       dbz;
`endif

    typedef struct {
        logic [3:0] q;
        logic [2:0] r;
        logic       z;
    } expT;

    expT sbQ[$];
    int  assertCount = 0;
    int  failCount   = 0;

    train_step_sdiv_4s_3s_seq #(
        .ID        (1),
        .din0_WIDTH(4),
        .din1_WIDTH(3)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst   (ap_rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .din0     (din0),
        .din1     (din1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quot     (quot),
        .rem      (rem)
`ifdef TRAIN_STEP_SDIV_DBZ_FLAG_EN
        ,
        .dbz      (dbz)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    // C semantics: '/' truncates toward zero and '%' takes the dividend's sign.
    function automatic expT refModel(input int a, input int b);
        expT e;
        int  qi;
        int  ri;
        if (b == 0) begin
            e.q = 4'hF;
            e.r = 3'd0;
            e.z = 1'b1;
        end else begin
            qi  = a / b;
            ri  = a % b;
            e.q = qi[3:0];
            e.r = ri[2:0];
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic applyStimulus(input int a, input int b);
        int guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge ap_clk); #1;
            guard++;
        end
        if (in_ready !== 1'b1) begin
            checkOutput("inReadyTimeout", 32'(in_ready), 32'd1);
        end
        in_valid = 1'b1;
        din0     = a[3:0];
        din1     = b[2:0];
        sbQ.push_back(refModel(a, b));
        @(posedge ap_clk); #1;
        in_valid = 1'b0;
        din0     = 4'($urandom);
        din1     = 3'($urandom);
    endtask

    task automatic collectResult(input int holdCycles);
        int         n = 0;
        expT        e;
        logic [3:0] heldQ;
        logic [2:0] heldR;
        while (out_valid !== 1'b1 && n < 20) begin
            @(posedge ap_clk); #1;
            n++;
        end
        checkOutput("latency", 32'(n), 32'd5);
        if (sbQ.size() == 0) begin
            checkOutput("sbUnderflow", 32'd0, 32'd1);
            return;
        end
        e = sbQ.pop_front();
        if (out_valid !== 1'b1) begin
            return;
        end
        checkOutput("quot", 32'(quot), 32'(e.q));
        checkOutput("rem", 32'(rem), 32'(e.r));
`ifdef TRAIN_STEP_SDIV_DBZ_FLAG_EN
        checkOutput("dbz", 32'(dbz), 32'(e.z));
`endif
        heldQ = quot;
        heldR = rem;
        for (int i = 0; i < holdCycles; i++) begin
            in_valid = 1'b1;
            din0     = 4'($urandom);
            din1     = 3'($urandom);
            @(posedge ap_clk); #1;
            checkOutput("holdValid", 32'(out_valid), 32'd1);
            checkOutput("holdInReady", 32'(in_ready), 32'd0);
            checkOutput("holdQuot", 32'(quot), 32'(e.q));
            checkOutput("holdRem", 32'(rem), 32'(e.r));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge ap_clk); #1;
        out_ready = 1'b0;
        checkOutput("releaseValid", 32'(out_valid), 32'd0);
        checkOutput("releaseInReady", 32'(in_ready), 32'd1);
`ifdef TRAIN_STEP_SDIV_DBZ_FLAG_EN
        checkOutput("releaseDbz", 32'(dbz), 32'd0);
`endif
        if (holdCycles > 0) begin
            checkOutput("heldQuotMatch", 32'(heldQ), 32'(e.q));
            checkOutput("heldRemMatch", 32'(heldR), 32'(e.r));
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dirA[7] = '{7, -7, 7, -8, -8, 5, 6};
        int dirB[7] = '{3, 3, -3, -1, 3, 0, 2};
        int seen;

        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = 4'd0;
        din1      = 3'd0;
        repeat (3) @(posedge ap_clk);
        #1;
        checkOutput("rstInReady", 32'(in_ready), 32'd1);
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstQuot", 32'(quot), 32'd0);
        checkOutput("rstRem", 32'(rem), 32'd0);
`ifdef TRAIN_STEP_SDIV_DBZ_FLAG_EN
        checkOutput("rstDbz", 32'(dbz), 32'd0);
`endif
        ap_rst = 1'b0;

        $display("[TB] directed cases");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(dirA[i], dirB[i]);
            collectResult(0);
        end

        $display("[TB] backpressure hold in DONE");
        applyStimulus(-5, 2);
        collectResult(6);
        applyStimulus(3, -2);
        collectResult(0);

        $display("[TB] reset during CALC");
        applyStimulus(5, 1);
        @(posedge ap_clk); #1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        void'(sbQ.pop_back());
        checkOutput("midRstInReady", 32'(in_ready), 32'd1);
        checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
        checkOutput("midRstQuot", 32'(quot), 32'd0);
        seen = 0;
        repeat (8) begin
            @(posedge ap_clk); #1;
            if (out_valid === 1'b1) seen = 1;
        end
        checkOutput("midRstNoPulse", 32'(seen), 32'd0);
        applyStimulus(6, 2);
        collectResult(0);

        $display("[TB] exhaustive sweep");
        for (int a = -8; a < 8; a++) begin
            for (int b = -4; b < 4; b++) begin
                applyStimulus(a, b);
                collectResult(int'($urandom_range(0, 1)));
            end
        end

        checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
